// File: rtl/stm_trace_emitter_pkg.sv
`default_nettype none
// dbg_stm_pkg -- shared encodings and field positions for the STM trace emitter. Rev 1.0
// DBG_STM_TIMESTAMP_EN selects whether timestamp words are carried in packets.
`ifndef DBG_TIMESTAMP_WIDTH
`define DBG_TIMESTAMP_WIDTH 32
`endif

package dbg_stm_pkg;

  localparam int FLIT_W        = 16;
  localparam int DROP_W        = 7;
  localparam int SAMPLE_CORE_W = 48;

  // Sample layout: {timestamp, value[31:0], id[15:0]}
  localparam int ID_LSB  = 0;
  localparam int VAL_LSB = 16;
  localparam int TS_LSB  = 48;

  // Source flit layout: {drop_flag, drop_cnt[6:0], src_id[7:0]}
  localparam int SRC_FLAG_BIT = 15;
  localparam int SRC_CNT_LSB  = 8;
  localparam int SRC_ID_LSB   = 0;

`ifdef DBG_STM_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_SRC  = 3'd2,
    S_ID   = 3'd3,
    S_VHI  = 3'd4,
    S_VLO  = 3'd5,
    S_TS   = 3'd6
  } state_t;

  function automatic int pkt_len(input int ts_w, input bit ts_en);
    return ts_en ? 5 + ts_w / FLIT_W : 5;
  endfunction

  function automatic logic [FLIT_W-1:0] src_flit(input logic [DROP_W-1:0] cnt,
                                                 input logic [7:0] src);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[SRC_FLAG_BIT]           = |cnt;
    f[SRC_CNT_LSB +: DROP_W]  = cnt;
    f[SRC_ID_LSB +: 8]        = src;
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stm_trace_fifo.sv
`default_nettype none
// stm_trace_fifo -- synchronous sample FIFO, power-of-2 depth, extra-MSB pointers. Rev 1.0

module stm_trace_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/stm_trace_emitter.sv
`default_nettype none
// stm_trace_emitter -- buffers STM trace samples and emits them as 16-bit debug NoC packets. Rev 1.0
// DBG_STM_TIMESTAMP_EN adds the timestamp words to each packet and to the FIFO entries.

module stm_trace_emitter
  import dbg_stm_pkg::*;
#(
  parameter int          TIMESTAMP_WIDTH = `DBG_TIMESTAMP_WIDTH,
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [15:0] DEST_ID         = 16'h0000,
  parameter logic [7:0]  SRC_ID          = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TIMESTAMP_WIDTH+47:0] trace_din,
  input  logic                       trace_valid,
  output logic [15:0]                out_flit,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       overflow
);

`ifdef DBG_STM_TIMESTAMP_EN
  localparam int SW       = TIMESTAMP_WIDTH + SAMPLE_CORE_W;
  localparam int TS_WORDS = TIMESTAMP_WIDTH / FLIT_W;
  localparam int WCW      = $clog2(TS_WORDS + 1);
  logic [WCW-1:0] word_cnt;
`else
  localparam int SW = SAMPLE_CORE_W;
  logic unused_ts;
  assign unused_ts = ^trace_din[TIMESTAMP_WIDTH+SAMPLE_CORE_W-1:SAMPLE_CORE_W];
`endif

  state_t            state;
  logic [SW-1:0]     pkt;
  logic [SW-1:0]     head;
  logic [DROP_W-1:0] drop_cnt;
  logic [DROP_W-1:0] cnt_next;
  logic              full, empty, push, pop, drop, accept, pkt_done;

  assign push     = trace_valid && !full;
  assign drop     = trace_valid && full;
  assign accept   = out_valid && out_ready;
  assign pkt_done = accept && out_last;
  assign pop      = !empty && ((state == S_IDLE) || pkt_done);
  assign cnt_next = (drop && (drop_cnt != '1)) ? drop_cnt + DROP_W'(1) : drop_cnt;

  stm_trace_fifo #(
    .WIDTH (SW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (trace_din[SW-1:0]),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // A drop landing in the same cycle the source flit is taken starts the next count at 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= drop;
      if (state == S_SRC && accept)
        drop_cnt <= {{(DROP_W-1){1'b0}}, drop};
      else
        drop_cnt <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      pkt       <= '0;
      out_flit  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
`ifdef DBG_STM_TIMESTAMP_EN
      word_cnt  <= '0;
`endif
    end else if (pop) begin
      pkt       <= head;
      state     <= S_HDR;
      out_flit  <= DEST_ID;
      out_valid <= 1'b1;
      out_last  <= 1'b0;
    end else if (pkt_done) begin
      state     <= S_IDLE;
      out_flit  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept) begin
      unique case (state)
        S_HDR: begin
          state    <= S_SRC;
          out_flit <= src_flit(cnt_next, SRC_ID);
        end
        S_SRC: begin
          state    <= S_ID;
          out_flit <= pkt[ID_LSB +: FLIT_W];
        end
        S_ID: begin
          state    <= S_VHI;
          out_flit <= pkt[VAL_LSB+FLIT_W +: FLIT_W];
        end
        S_VHI: begin
          state    <= S_VLO;
          out_flit <= pkt[VAL_LSB +: FLIT_W];
`ifndef DBG_STM_TIMESTAMP_EN
          out_last <= 1'b1;
`endif
        end
`ifdef DBG_STM_TIMESTAMP_EN
        // Timestamp field is shifted up so the next word is always at the top.
        S_VLO: begin
          state              <= S_TS;
          out_flit           <= pkt[SW-1 -: FLIT_W];
          pkt[SW-1:TS_LSB]   <= pkt[SW-1:TS_LSB] << FLIT_W;
          word_cnt           <= WCW'(1);
          out_last           <= (TS_WORDS == 1);
        end
        S_TS: begin
          out_flit           <= pkt[SW-1 -: FLIT_W];
          pkt[SW-1:TS_LSB]   <= pkt[SW-1:TS_LSB] << FLIT_W;
          word_cnt           <= word_cnt + WCW'(1);
          out_last           <= (word_cnt == WCW'(TS_WORDS - 1));
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stm_trace_emitter.sv
`default_nettype none
// tb_stm_trace_emitter -- directed bench for stm_trace_emitter (either DBG_STM_TIMESTAMP_EN build). Rev 1.0

module tb_stm_trace_emitter;
  import dbg_stm_pkg::*;

  localparam int TSW = 32;
  localparam int PL  = pkt_len(TSW, TS_EN);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [TSW+47:0] trace_din = '0;
  logic            trace_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [15:0]     out_flit;
  logic            out_valid, out_last, overflow;

  stm_trace_emitter #(
    .TIMESTAMP_WIDTH (TSW),
    .FIFO_DEPTH      (4),
    .DEST_ID         (16'h0003),
    .SRC_ID          (8'h5A)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trace_din   (trace_din),
    .trace_valid (trace_valid),
    .out_flit    (out_flit),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        tv;
    logic        rdy;
    logic        exp_valid;
    logic [15:0] exp_flit;
    logic        exp_last;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [16:0] exp_q[$];
  vec_t        vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TSW+47:0] mk(input logic [15:0] id);
    return {32'h0001_0002, 32'hDEAD_BEEF, id};
  endfunction

  // Expected flits of one packet as {last, flit}
  function automatic void add_pkt(input logic [15:0] id, input logic [15:0] src);
    exp_q.push_back({1'b0, 16'h0003});
    exp_q.push_back({1'b0, src});
    exp_q.push_back({1'b0, id});
    exp_q.push_back({1'b0, 16'hDEAD});
    if (TS_EN) begin
      exp_q.push_back({1'b0, 16'hBEEF});
      exp_q.push_back({1'b0, 16'h0001});
      exp_q.push_back({1'b1, 16'h0002});
    end else begin
      exp_q.push_back({1'b1, 16'hBEEF});
    end
  endfunction

  task automatic reset_dut();
    rst = 1'b0;
    trace_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Drains exp_q against accepted flits; ready follows pat cyclically.
  task automatic collect(input logic [3:0] pat, output int gaps);
    int          cyc;
    bit          started;
    bit          stalled;
    logic [15:0] prev_flit;
    logic [16:0] e;
    cyc = 0; started = 0; stalled = 0; gaps = 0; prev_flit = '0;
    while (exp_q.size() > 0 && cyc < 400) begin
      out_ready = pat[cyc % 4];
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_flit", out_flit, prev_flit);
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        chk($sformatf("flit_cyc%0d", cyc), {out_last, out_flit}, e);
        started = 1;
      end else if (started && !out_valid) begin
        gaps++;
      end
      stalled   = out_valid && !out_ready;
      prev_flit = out_flit;
      cyc++;
      tick();
    end
    if (exp_q.size() != 0) begin
      chk("collect_timeout_remaining", exp_q.size(), 0);
      exp_q.delete();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    int ovf;
    int gaps;
    bit found;

    // Reset held with trace_valid high
    rst = 1'b0;
    trace_valid = 1'b1;
    trace_din = mk(16'h7777);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_flit", out_flit, 0);
      chk("rst_last", out_last, 0);
    end
    trace_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_idle", out_valid, 0);
    end

    // Single event, cycle-exact table with out_ready held high
    add_pkt(16'h1234, 16'h005A);
    vt.push_back('{tv: 1'b1, rdy: 1'b1, exp_valid: 1'b0, exp_flit: 16'h0, exp_last: 1'b0});
    for (int k = 0; k < PL; k++)
      vt.push_back('{tv: 1'b0, rdy: 1'b1, exp_valid: 1'b1,
                     exp_flit: exp_q[k][15:0], exp_last: exp_q[k][16]});
    vt.push_back('{tv: 1'b0, rdy: 1'b1, exp_valid: 1'b0, exp_flit: 16'h0, exp_last: 1'b0});
    exp_q.delete();
    trace_din = mk(16'h1234);
    for (int i = 0; i < vt.size(); i++) begin
      trace_valid = vt[i].tv;
      out_ready   = vt[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid, vt[i].exp_valid);
      chk($sformatf("vec%0d_flit", i), out_flit, vt[i].exp_flit);
      chk($sformatf("vec%0d_last", i), out_last, vt[i].exp_last);
      chk($sformatf("vec%0d_ovf", i), overflow, 0);
    end
    trace_valid = 1'b0;

    // Backpressure: ready pattern 1,0,0,1 repeating
    reset_dut();
    trace_din = mk(16'h1234);
    trace_valid = 1'b1;
    tick();
    trace_valid = 1'b0;
    add_pkt(16'h1234, 16'h005A);
    collect(4'b1001, gaps);

    // Overflow: one packet already stalled in HDR, then 6 events into a 4-deep FIFO
    reset_dut();
    trace_din = mk(16'h1111);
    trace_valid = 1'b1;
    tick();
    trace_valid = 1'b0;
    tick();
    chk("ovf_hdr_valid", out_valid, 1);
    chk("ovf_hdr_flit", out_flit, 16'h0003);
    ovf = 0;
    for (int i = 0; i < 6; i++) begin
      trace_din = mk(16'hA000 + 16'(i));
      trace_valid = 1'b1;
      tick();
      ovf += int'(overflow);
    end
    trace_valid = 1'b0;
    tick();
    ovf += int'(overflow);
    chk("ovf_pulses", ovf, 2);
    add_pkt(16'h1111, 16'h825A);
    for (int i = 0; i < 4; i++)
      add_pkt(16'hA000 + 16'(i), 16'h005A);
    collect(4'b1111, gaps);

    // Back-to-back: three queued events, no idle cycle between packets
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      trace_din = mk(16'h0B01 + 16'(i));
      trace_valid = 1'b1;
      tick();
    end
    trace_valid = 1'b0;
    for (int i = 0; i < 3; i++)
      add_pkt(16'h0B01 + 16'(i), 16'h005A);
    collect(4'b1111, gaps);
    chk("b2b_gaps", gaps, 0);
    chk("b2b_idle_after", out_valid, 0);

    // Reset mid-packet after the id flit is taken, with a second sample queued
    reset_dut();
    out_ready = 1'b1;
    trace_din = mk(16'h1234);
    trace_valid = 1'b1;
    tick();
    trace_din = mk(16'h5678);
    tick();
    trace_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid && out_flit == 16'h1234) found = 1;
      else tick();
    end
    chk("mid_rst_saw_id", found, 1);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_flit", out_flit, 0);
    chk("mid_rst_last", out_last, 0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_rst_fifo_empty", out_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/stm_trace_emitter.md
Name: stm_trace_emitter

Overview:
Consumer end of the STM data shift register. It captures delayed trace samples {timestamp, value, id} when the delayed trigger fires and buffers them in a small FIFO. It serialises each sample into a 16-bit-flit debug NoC packet using a valid/ready handshake. When the FIFO is full, new events are dropped and counted, and the count is reported in the next emitted packet.

Parameters:
TIMESTAMP_WIDTH, `DBG_TIMESTAMP_WIDTH, timestamp bits in the sample; must be a nonzero multiple of 16.
FIFO_DEPTH, 4, sample buffer entries; must be a power of 2 and at least 2.
DEST_ID, 16'h0000, destination address placed in header flit 0.
SRC_ID, 8'h00, module ID placed in flit 1.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low (asserted when 0)
trace_din  in  TIMESTAMP_WIDTH+48  delayed sample {timestamp, value[31:0], id[15:0]}, timestamp in the MSBs
trace_valid  in  1  delayed trigger; sample is captured when high
out_flit  out  16  NoC flit
out_valid  out  1  flit valid
out_last  out  1  last flit of the packet
out_ready  in  1  downstream accepts the flit
overflow  out  1  registered; high for one cycle on each dropped event

Behaviour:
- Reset (rst==0 at posedge):
  - FIFO is emptied, FSM goes to IDLE, drop counter is cleared.
  - out_valid=0, out_last=0, out_flit=0, overflow=0.
  - Reset mid-packet abandons the packet; no partial flits follow.
- Capture:
  - trace_valid=1 with FIFO not full: push trace_din.
  - trace_valid=1 with FIFO full: drop the sample, pulse overflow next cycle, drop_cnt saturating +1 (7 bits, max 127).
  - A pop in the same cycle does not free a slot for that cycle's push. Full is evaluated before the pop.
- Flit handshake: a flit transfers when out_valid && out_ready. While out_valid=1, out_flit and out_last are held stable.
- FSM states: IDLE, HDR, SRC, ID, VHI, VLO, TS.
  - IDLE: FIFO non-empty → HDR next cycle. The head entry is latched into a packet register and popped. Push-to-first-flit latency is 2 cycles.
  - HDR: out_flit = DEST_ID.
  - SRC: out_flit = {drop_cnt!=0, drop_cnt[6:0], SRC_ID}. drop_cnt is cleared on acceptance. A drop in that same cycle sets drop_cnt to 1.
  - ID: out_flit = id.
  - VHI: out_flit = value[31:16].
  - VLO: out_flit = value[15:0].
  - TS: timestamp sent MSB word first, TIMESTAMP_WIDTH/16 flits, tracked by a word counter. out_last=1 on the final word.
- Each state advances only on acceptance.
- After the last flit is accepted:
  - FIFO non-empty → HDR directly; packets are back-to-back.
  - FIFO empty → IDLE.
- Packet length is 5 + TIMESTAMP_WIDTH/16 flits.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. full/empty are derived from the extra MSB.

Optional Feature:
DBG_STM_TIMESTAMP_EN
- Defined: the TS state exists and timestamp flits are emitted. out_last is set on the final TS word.
- Undefined: the TS state is removed and the packet is 5 flits. out_last is set in VLO. Timestamp bits are neither stored in the FIFO nor sent; FIFO width is 48 bits.

Decomposition:
- Shared package dbg_stm_pkg:
  - FSM state encoding.
  - Flit width (16).
  - Header field positions.
  - drop_cnt width (7).
  - Packet length function of TIMESTAMP_WIDTH.
- One sub-module, stm_trace_fifo: parameterised sync FIFO with push/pop/full/empty, same clk and rst.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with trace_valid=1 → out_valid=0, overflow=0. No packet appears after rst rises unless trace_valid is still asserted.
2. Single event, TIMESTAMP_WIDTH=32, feature on, DEST_ID=16'h0003, SRC_ID=8'h5A, id=16'h1234, value=32'hDEADBEEF, ts=32'h00010002, out_ready=1:
   - Flits 0003, 005A, 1234, DEAD, BEEF, 0001, 0002.
   - out_last only on 0002.
   - First flit appears 2 cycles after capture.
3. Backpressure: same event with out_ready toggling 1,0,0,1,... → flit sequence unchanged and out_flit stable while stalled.
4. Overflow: out_ready=0, 6 consecutive trace_valid with FIFO_DEPTH=4 → 2 overflow pulses. Then with out_ready=1, the first packet's flit 1 = 16'h825A and later packets carry 16'h005A.
5. Back-to-back: 3 events queued, out_ready=1 → three 7-flit packets with no idle cycle between them.
6. Feature off: the single event of scenario 2 → 5 flits, out_last on BEEF. Reset mid-packet (after the 1234 flit) → out_valid=0 next cycle and the FIFO is empty.
